dm_multicycle: RTL and testbench

//  Parametrised byte-addressed data memory with a valid/ready request port, a fixed configurable access latency,

---
 rtl/dm_pkg.sv | 33 +++
 rtl/dm_multicycle_if.sv | 25 ++
 rtl/dm_lane_align.sv | 43 ++++
 rtl/dm_multicycle.sv | 145 ++++++++++++++
 tb/tb_dm_multicycle.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the multicycle data memory.
package dm_pkg;

  localparam logic [1:0] DM_SZ_B = 2'b00;
  localparam logic [1:0] DM_SZ_H = 2'b01;
  localparam logic [1:0] DM_SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dm_state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_req_t;

  // Number of bytes touched by an access; the reserved code reports 4 but is flagged as an error.
  function automatic logic [2:0] dm_size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      DM_SZ_B: n = 3'd1;
      DM_SZ_H: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dm_multicycle_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface dm_multicycle_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering: byte enables for stores and extended load data.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(raw >> {offset, 3'b000});
  assign half_sel = offset[1] ? raw[31:16] : raw[15:0];

  // Select enables and extend the addressed lanes according to the access size.
  always_comb begin
    be    = 4'b0000;
    rdata = 32'h0;
    unique case (size)
      DM_SZ_B: begin
        be    = 4'b0001 << offset;
        rdata = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      DM_SZ_H: begin
        be    = 4'b0011 << offset;
        rdata = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      DM_SZ_W: begin
        be    = 4'b1111;
        rdata = raw;
      end
      default: begin
        be    = 4'b0000;
        rdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dm_multicycle.sv
// Byte-addressed data memory with fixed access latency and error reporting.
// Optional feature: define DM_ZERO_ON_RST_EN to clear the whole array on every reset cycle.
module dm_multicycle
  import dm_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned CNT_W     = 4
) (
  input logic             clk,
  input logic             rst,
  dm_multicycle_if.slave  bus
);

  localparam int unsigned AW = (MEM_BYTES > 4) ? $clog2(MEM_BYTES) : 2;

  dm_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dm_req_t          req_q;
  logic             accept;
  logic             commit;

  logic [7:0]       data_mem [MEM_BYTES];
  logic [AW-1:0]    lane_idx [4];
  logic [31:0]      raw;
  logic [31:0]      wlane;
  logic [3:0]       be;
  logic [31:0]      load_data;
  logic [32:0]      end_addr;
  logic             misalign;
  logic             acc_err;
  logic [31:0]      rdata_q;
  logic             err_q;

  assign accept = bus.req_valid && (state_q == IDLE);

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; commit marks the edge that performs the access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; response data comes from its own registers.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

  // Request register: captures the bus only on the accepting edge.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      req_q.we          <= bus.req_we;
      req_q.size        <= bus.req_size;
      req_q.is_unsigned <= bus.req_unsigned;
      req_q.addr        <= bus.req_addr;
      req_q.wdata       <= bus.req_wdata;
    end
  end

  // Bytes of the aligned word containing the address; lanes past the array read as zero.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign lane_idx[g]   = {req_q.addr[AW-1:2], 2'(g)};
    assign raw[8*g +: 8] = (32'(lane_idx[g]) < MEM_BYTES) ? data_mem[lane_idx[g]] : 8'h00;
  end

  // Access check; 33-bit end address so high addresses cannot wrap into range.
  always_comb begin
    end_addr = {1'b0, req_q.addr} + 33'(dm_size_bytes(req_q.size)) - 33'd1;
    misalign = ((req_q.size == DM_SZ_H) && req_q.addr[0]) ||
               ((req_q.size == DM_SZ_W) && (req_q.addr[1:0] != 2'b00));
    acc_err  = (req_q.size == 2'b11) || misalign || (end_addr >= 33'(MEM_BYTES));
  end

  assign wlane = req_q.wdata << {req_q.addr[1:0], 3'b000};

  dm_lane_align u_lane_align (
    .offset      (req_q.addr[1:0]),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .raw         (raw),
    .be          (be),
    .rdata       (load_data)
  );

  // Storage: enabled-lane writes at the commit edge, optional clear while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DM_ZERO_ON_RST_EN
      for (int i = 0; i < int'(MEM_BYTES); i++) begin
        data_mem[AW'(i)] <= 8'h00;
      end
`endif
    end else if (commit && req_q.we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          data_mem[lane_idx[i]] <= wlane[8*i +: 8];
        end
      end
    end
  end

  // Response registers, loaded at commit and held until the next commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q   <= acc_err;
      rdata_q <= (acc_err || req_q.we) ? 32'h0 : load_data;
    end
  end

endmodule

// File: tb/tb_dm_multicycle.sv
// Directed self-checking bench for dm_multicycle.
module tb_dm_multicycle;
  import dm_pkg::*;

  localparam int unsigned LAT = 2;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  dm_multicycle_if bus ();

  dm_multicycle #(
    .MEM_BYTES (128),
    .LATENCY   (LAT),
    .CNT_W     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request, then reports latency, response and handshake observations.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic ready_low, output logic pulse_one);
    int w;
    lat       = 0;
    rdata     = 'x;
    err       = 'x;
    ready_low = 1'b1;
    pulse_one = 1'b0;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    // Scramble the bus during BUSY; it must not affect the access.
    bus.req_valid    = 1'b0;
    bus.req_we       = ~we;
    bus.req_size     = 2'b11;
    bus.req_unsigned = ~uns;
    bus.req_addr     = 32'h0000_0000;
    bus.req_wdata    = 32'hFFFF_FFFF;
    for (int n = 1; n <= 20; n++) begin
      if (bus.req_ready) ready_low = 1'b0;
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        lat   = n;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        if (bus.req_ready) ready_low = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    pulse_one = !bus.rsp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata);
    end
    checks++;
    if (bus.rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", bus.rsp_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word_rw();
    int lat; logic [31:0] rd; logic er, rl, p1;
    access(1'b1, DM_SZ_W, 1'b0, 32'h10, 32'h8000_00FF, lat, rd, er, rl, p1);
    checks++;
    if (lat !== int'(LAT)) begin errors++; $display("FAIL sw_latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL sw_rsp: got err=%b rdata=%h want err=0 rdata=0", er, rd);
    end
    checks++;
    if (rl !== 1'b1 || p1 !== 1'b1) begin
      errors++; $display("FAIL sw_handshake: got ready_low=%b pulse=%b want 1 1", rl, p1);
    end
    access(1'b0, DM_SZ_W, 1'b0, 32'h10, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (lat !== int'(LAT)) begin errors++; $display("FAIL lw_latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (rd !== 32'h8000_00FF || er !== 1'b0) begin
      errors++; $display("FAIL lw_data: got %h err=%b want 800000ff err=0", rd, er);
    end
    checks++;
    if (rl !== 1'b1 || p1 !== 1'b1) begin
      errors++; $display("FAIL lw_handshake: got ready_low=%b pulse=%b want 1 1", rl, p1);
    end
  endtask

  task automatic test_sub_word();
    int lat; logic [31:0] rd; logic er, rl, p1;
    access(1'b1, DM_SZ_B, 1'b0, 32'h13, 32'h1234_56AB, lat, rd, er, rl, p1);
    access(1'b0, DM_SZ_B, 1'b0, 32'h13, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (rd !== 32'hFFFF_FFAB || er !== 1'b0) begin
      errors++; $display("FAIL lb: got %h err=%b want ffffffab err=0", rd, er);
    end
    access(1'b0, DM_SZ_B, 1'b1, 32'h13, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (rd !== 32'h0000_00AB) begin errors++; $display("FAIL lbu: got %h want 000000ab", rd); end
    access(1'b0, DM_SZ_W, 1'b0, 32'h10, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (rd !== 32'hAB00_00FF) begin errors++; $display("FAIL lw_after_sb: got %h want ab0000ff", rd); end
    access(1'b0, DM_SZ_H, 1'b0, 32'h12, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (rd !== 32'hFFFF_AB00) begin errors++; $display("FAIL lh: got %h want ffffab00", rd); end
    access(1'b0, DM_SZ_H, 1'b1, 32'h12, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (rd !== 32'h0000_AB00) begin errors++; $display("FAIL lhu: got %h want 0000ab00", rd); end
    access(1'b0, DM_SZ_B, 1'b1, 32'h10, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL lbu_lane0: got %h want 000000ff", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er, rl, p1;
    access(1'b1, DM_SZ_H, 1'b0, 32'h11, 32'h0000_5555, lat, rd, er, rl, p1);
    checks++;
    if (er !== 1'b1 || lat !== int'(LAT)) begin
      errors++; $display("FAIL sh_misalign: got err=%b lat=%0d want 1 %0d", er, lat, LAT);
    end
    access(1'b0, DM_SZ_W, 1'b0, 32'h10, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (rd !== 32'hAB00_00FF || er !== 1'b0) begin
      errors++; $display("FAIL lw_unchanged: got %h err=%b want ab0000ff 0", rd, er);
    end
    access(1'b1, DM_SZ_W, 1'b0, 32'h7C, 32'hDEAD_BEEF, lat, rd, er, rl, p1);
    access(1'b0, DM_SZ_W, 1'b0, 32'h7C, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      errors++; $display("FAIL lw_top: got %h err=%b want deadbeef 0", rd, er);
    end
    access(1'b0, DM_SZ_W, 1'b0, 32'h80, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++; $display("FAIL lw_oor: got %h err=%b want 0 1", rd, er);
    end
    access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++; $display("FAIL size_rsvd: got %h err=%b want 0 1", rd, er);
    end
    access(1'b0, DM_SZ_W, 1'b0, 32'h12, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL lw_misalign: got err=%b want 1", er); end
    access(1'b0, DM_SZ_W, 1'b0, 32'hFFFF_FFFC, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL lw_wrap: got %h err=%b want 0 1", rd, er);
    end
    access(1'b0, DM_SZ_H, 1'b1, 32'h7E, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0000_DEAD) begin
      errors++; $display("FAIL lhu_top: got %h err=%b want 0000dead 0", rd, er);
    end
    access(1'b1, DM_SZ_B, 1'b0, 32'h80, 32'h0000_0011, lat, rd, er, rl, p1);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL sb_oor: got err=%b want 1", er); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er, rl, p1;
    logic [31:0] prior;
    int seen;
    access(1'b1, DM_SZ_W, 1'b0, 32'h20, 32'hCAFE_F00D, lat, rd, er, rl, p1);
`ifdef DM_ZERO_ON_RST_EN
    prior = 32'h0;
`else
    prior = 32'hCAFE_F00D;
`endif
    // Store accepted, then reset while BUSY.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = DM_SZ_W;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_rsp: got %0d pulses want 0", seen); end
    // Reset and request on the same edge: reset wins.
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_wins: got %0d pulses want 0", seen); end
    access(1'b0, DM_SZ_W, 1'b0, 32'h20, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (rd !== prior || er !== 1'b0) begin
      errors++; $display("FAIL abort_no_write: got %h err=%b want %h 0", rd, er, prior);
    end
  endtask

  task automatic test_mem_reset();
    int lat; logic [31:0] rd; logic er, rl, p1;
    logic [31:0] expect_v;
    access(1'b1, DM_SZ_W, 1'b0, 32'h04, 32'h5A5A_A5A5, lat, rd, er, rl, p1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
`ifdef DM_ZERO_ON_RST_EN
    expect_v = 32'h0;
`else
    expect_v = 32'h5A5A_A5A5;
`endif
    access(1'b0, DM_SZ_W, 1'b0, 32'h04, 32'h0, lat, rd, er, rl, p1);
    checks++;
    if (rd !== expect_v || er !== 1'b0) begin
      errors++; $display("FAIL mem_after_rst: got %h err=%b want %h 0", rd, er, expect_v);
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = DM_SZ_W;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    test_reset();
    test_word_rw();
    test_sub_word();
    test_errors();
    test_reset_abort();
    test_mem_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
